// File: rtl/siso_shift_sequencer_pkg.sv
// Shared types and sizing for the serial shift sequencer.
// Pure declarations: no latency, no flow control.
package siso_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int GAP_W     = 4;

    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/siso_shift_sequencer_if.sv
// Word-in / bit-out bundle between producer, sequencer and the serial chain.
// master = producer/downstream side, slave = sequencer.
interface siso_shift_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_msb_first;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             busy;
    logic             frame_done;

    modport master (
        output in_valid, in_data, in_msb_first, shift_en,
        input  in_ready, sout, sout_valid, sout_last, busy, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_msb_first, shift_en,
        output in_ready, sout, sout_valid, sout_last, busy, frame_done
    );
endinterface

// File: rtl/siso_shift_sequencer_bit_counter.sv
// Wrapping up-counter 0..MAX with synchronous clear (clear wins over increment).
// Count is registered; at_max is combinational from the count.
module siso_bit_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/siso_shift_sequencer.sv
// Loads a word on handshake, emits it one bit per shift_en cycle, then idles GAP cycles.
// First bit one cycle after handshake; shift_en=0 freezes the frame; in_ready only in IDLE.
module siso_shift_sequencer
    import siso_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    siso_shift_sequencer_if.slave  bus
);

    localparam int BW      = cnt_w(WIDTH);
    localparam int GAP_MAX = (GAP > 0) ? GAP - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic             msb_q;
    logic             done_q;
    logic [BW-1:0]    bit_cnt;
    logic             bit_at_max;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_at_max;

    logic             ready_c;
    logic             busy_c;
    logic             vld_c;
    logic             last_c;
    logic             hs;
    logic             xfer;
    logic             last_xfer;

    assign hs        = bus.in_valid & ready_c;
    assign xfer      = vld_c;
    assign last_xfer = xfer & bit_at_max;

    siso_bit_counter #(.MAX(WIDTH - 1), .W(BW)) u_bit_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (hs),
        .inc    (xfer),
        .count  (bit_cnt),
        .at_max (bit_at_max)
    );

    siso_bit_counter #(.MAX(GAP_MAX), .W(GAP_W)) u_gap_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (last_xfer),
        .inc    (state == S_GAP),
        .count  (gap_cnt),
        .at_max (gap_at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = S_SHIFT;
            S_SHIFT: if (last_xfer) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (gap_at_max) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready_c = 1'b0;
        busy_c  = 1'b0;
        vld_c   = 1'b0;
        last_c  = 1'b0;
        case (state)
            S_IDLE:  ready_c = 1'b1;
            S_SHIFT: begin
                busy_c = 1'b1;
                vld_c  = bus.shift_en;
                last_c = bus.shift_en & bit_at_max;
            end
            S_GAP:   busy_c = 1'b1;
            default: ready_c = 1'b0;
        endcase
    end

    // Shifting zeros in leaves the register clear once a frame completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg  <= '0;
            msb_q <= 1'b0;
        end else if (hs) begin
            sreg  <= bus.in_data;
            msb_q <= bus.in_msb_first;
        end else if (xfer) begin
            sreg  <= msb_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_xfer;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.busy       = busy_c;
    assign bus.sout_valid = vld_c;
    assign bus.sout_last  = last_c;
    assign bus.sout       = msb_q ? sreg[WIDTH-1] : sreg[0];
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_siso_shift_sequencer.sv
// Directed bench: GAP=2 instance for framing/stall/reset cases, GAP=0 instance for back-to-back.
module tb_siso_shift_sequencer;

    localparam int W = 8;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    siso_shift_sequencer_if #(.WIDTH(W)) bus_a ();
    siso_shift_sequencer_if #(.WIDTH(W)) bus_b ();

    siso_shift_sequencer #(.WIDTH(W), .GAP(G)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    siso_shift_sequencer #(.WIDTH(W), .GAP(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // exp holds the serial stream in transfer order, first bit in exp[7].
    // stall[c] = 1 drops shift_en in cycle c after the handshake (cycle 1 = first bit).
    task automatic run_frame(input string tag, input logic [7:0] data, input logic msb,
                             input logic [7:0] exp, input logic [31:0] stall);
        int k = 0;
        int c = 1;
        bus_a.in_valid     = 1'b1;
        bus_a.in_data      = data;
        bus_a.in_msb_first = msb;
        bus_a.shift_en     = 1'b1;
        @(negedge clk);
        chk({tag, ".hs_rdy"}, bus_a.in_ready, 1);
        @(posedge clk); #1;
        bus_a.in_valid     = 1'b0;
        bus_a.in_data      = ~data;
        bus_a.in_msb_first = ~msb;
        while (k < 8 && c < 40) begin
            bus_a.shift_en = (c < 32) ? ~stall[c] : 1'b1;
            @(negedge clk);
            chk($sformatf("%s.sout%0d", tag, c), bus_a.sout, exp[7-k]);
            chk($sformatf("%s.vld%0d", tag, c), bus_a.sout_valid, bus_a.shift_en);
            chk($sformatf("%s.rdy%0d", tag, c), bus_a.in_ready, 0);
            chk($sformatf("%s.done%0d", tag, c), bus_a.frame_done, 0);
            if (bus_a.shift_en) begin
                chk($sformatf("%s.last%0d", tag, c), bus_a.sout_last, (k == 7));
                k++;
            end
            @(posedge clk); #1;
            c++;
        end
        chk({tag, ".nbits"}, k, 8);
        bus_a.shift_en = 1'b0;
        @(negedge clk);
        chk({tag, ".done"}, bus_a.frame_done, 1);
        chk({tag, ".gap_busy"}, bus_a.busy, 1);
        chk({tag, ".gap_rdy0"}, bus_a.in_ready, 0);
        for (int g = 1; g <= G; g++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("%s.gap_rdy%0d", tag, g), bus_a.in_ready, (g == G));
            chk($sformatf("%s.gap_done%0d", tag, g), bus_a.frame_done, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wb [3];
        wb = '{8'hC3, 8'h01, 8'h96};

        rst = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_msb_first = 1'b0; bus_a.shift_en = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_msb_first = 1'b0; bus_b.shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.rdy",  bus_a.in_ready, 1);
        chk("rst.busy", bus_a.busy, 0);
        chk("rst.sout", bus_a.sout, 0);
        chk("rst.vld",  bus_a.sout_valid, 0);
        chk("rst.last", bus_a.sout_last, 0);
        chk("rst.done", bus_a.frame_done, 0);
        @(posedge clk); #1;

        run_frame("a5_msb",   8'hA5, 1'b1, 8'b1010_0101, 32'h0);
        run_frame("a5_lsb",   8'hA5, 1'b0, 8'b1010_0101, 32'h0);
        run_frame("0f_lsb",   8'h0F, 1'b0, 8'b1111_0000, 32'h0);
        run_frame("3c_lsb",   8'h3C, 1'b0, 8'b0011_1100, 32'h0);
        run_frame("3c_stall", 8'h3C, 1'b1, 8'b0011_1100, 32'h0000_0038);
        run_frame("5a_alt",   8'h5A, 1'b1, 8'b0101_1010, 32'h5555_5554);

        // Abort 0xFF after four bits.
        bus_a.in_valid = 1'b1; bus_a.in_data = 8'hFF; bus_a.in_msb_first = 1'b1; bus_a.shift_en = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort.sout%0d", i), bus_a.sout, 1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.busy", bus_a.busy, 0);
        chk("abort.sout", bus_a.sout, 0);
        chk("abort.vld",  bus_a.sout_valid, 0);
        chk("abort.last", bus_a.sout_last, 0);
        chk("abort.rdy",  bus_a.in_ready, 1);
        chk("abort.done", bus_a.frame_done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort.done2", bus_a.frame_done, 0);
        chk("abort.busy2", bus_a.busy, 0);
        @(posedge clk); #1;
        run_frame("81_after", 8'h81, 1'b1, 8'b1000_0001, 32'h0);

        // GAP=0, in_valid held high: one handshake every WIDTH+1 cycles.
        bus_b.in_valid = 1'b1; bus_b.in_msb_first = 1'b1; bus_b.shift_en = 1'b1;
        bus_b.in_data  = wb[0];
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("b2b.rdy_w%0d", j), bus_b.in_ready, 1);
            chk($sformatf("b2b.done_w%0d", j), bus_b.frame_done, (j > 0));
            @(posedge clk); #1;
            bus_b.in_data = (j < 2) ? wb[j+1] : 8'h00;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk($sformatf("b2b.rdy_w%0d_b%0d", j, k), bus_b.in_ready, 0);
                chk($sformatf("b2b.sout_w%0d_b%0d", j, k), bus_b.sout, wb[j][7-k]);
                chk($sformatf("b2b.last_w%0d_b%0d", j, k), bus_b.sout_last, (k == 7));
                @(posedge clk); #1;
            end
        end
        bus_b.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b.done_end", bus_b.frame_done, 1);
        chk("b2b.rdy_end",  bus_b.in_ready, 1);
        chk("b2b.busy_end", bus_b.busy, 0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/siso_shift_sequencer.md
# siso_shift_sequencer

Controller that accepts parallel words over a valid/ready handshake and sequences them bit-serially into the SISO shift-register datapath, one bit per enabled clock. It owns the load, shift and gap phases, bit counting, bit ordering and frame-completion signalling. It sits between a word producer and the serial D-flip-flop chain.

## Interface
- WIDTH, 8: bits per frame; legal range 2..32.
- GAP, 2: idle cycles inserted after each frame before the next word is accepted; 0..15, where 0 means no gap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  sequencer can accept a word.
- in_data  in  WIDTH  parallel word; sampled on handshake.
- in_msb_first  in  1  bit order for this frame; sampled on handshake.
- shift_en  in  1  downstream advance enable; 0 stalls shifting.
- sout  out  1  serial data bit into the SISO chain.
- sout_valid  out  1  sout is a live bit this cycle.
- sout_last  out  1  sout is the final bit of the frame.
- busy  out  1  frame in progress (SHIFT or GAP).
- frame_done  out  1  one-cycle pulse after the final bit transfers.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, capture in_data and in_msb_first, clear bit_cnt, and go to SHIFT.
- SHIFT:
  - sout = in_data[WIDTH-1-bit_cnt] if msb_first, else in_data[bit_cnt]. Implement as a shift register shifted left or right.
  - sout_valid = shift_en. A transfer occurs when sout_valid=1.
  - On transfer, bit_cnt increments and the shift register advances.
  - With shift_en=0, all SHIFT state holds and sout holds its value.
  - sout_last = (bit_cnt==WIDTH-1) & sout_valid.
  - On the final-bit transfer, go to GAP (GAP>0) or IDLE (GAP=0), and assert frame_done the next cycle.
- GAP:
  - Counts GAP cycles regardless of shift_en, then goes to IDLE.
  - in_ready=0 throughout.
- busy = state!=IDLE. in_ready = state==IDLE.
- in_data changes outside the handshake cycle have no effect.
- in_valid in SHIFT or GAP is ignored and held off by in_ready=0.
- Reset values: state IDLE, bit_cnt 0, gap_cnt 0, shift register 0.
- Outputs after reset: sout=0, sout_valid=0, sout_last=0, busy=0, frame_done=0, in_ready=1.
- Reset mid-frame: the frame is aborted and frame_done is not pulsed. The next cycle is IDLE with all outputs at their reset values.

## Timing
- The handshake at edge N makes the first bit visible on sout in cycle N+1, with sout_valid=1 if shift_en=1.
- Unstalled frame length: WIDTH cycles of sout_valid.
- frame_done is a registered pulse in the cycle after the sout_last transfer.
- With GAP=g, in_ready rises g+1 cycles after the last-bit cycle.
- With GAP=0, in_ready rises in the cycle after the last bit, coincident with frame_done.
- Back-to-back frames need at least 1 idle cycle: the handshake cycle itself.
- sout_valid, sout_last and in_ready are combinational from registered state and shift_en. No input-to-output path other than shift_en.
- shift_en toggling every cycle produces exactly WIDTH transfers, with no duplicated or dropped bits.

## Structure
- Package siso_seq_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - CNT_W = $clog2(WIDTH);
  - GAP_W = 4.
- Sub-module siso_bit_counter:
  - parameter MAX;
  - inputs clr, inc;
  - outputs count and at_max;
  - instanced for bit_cnt and gap_cnt.
- Shift register and FSM live in the top module.

## Test plan
- WIDTH=8, GAP=2, load 0xA5 MSB-first with shift_en=1 -> sout 1,0,1,0,0,1,0,1 on cycles 1-8, sout_last on cycle 8, frame_done on cycle 9, in_ready=1 on cycle 11.
- Load 0xA5 LSB-first -> sout 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 LSB order. Checked against the 0x3C LSB-first check: 0,0,1,1,1,1,0,0.
- 0x3C MSB-first with shift_en low for cycles 3-5 -> exactly 8 valid bits 0,0,1,1,1,1,0,0; sout holds during the stall; frame_done only after the 8th transfer.
- in_valid held high continuously with GAP=0 -> words accepted every WIDTH+1 cycles; in_ready never high during SHIFT; no word lost.
- rst asserted after 4 bits of 0xFF -> next cycle IDLE, sout=0, busy=0, no frame_done pulse; a following 0x81 frame shifts out correctly.
- shift_en alternating 1/0 over 0x5A -> 8 transfers over 16 cycles, with a bit-exact serial stream.
